// File: rtl/video_pkg.sv
// Shared types for the camera-to-Avalon-ST video source.
// Holds the capture FSM states, the FIFO entry layout and a counter-width helper.
package video_pkg;

  localparam int VID_DW = 24;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    ACTIVE,
    FLUSH
  } vstate_t;

  typedef struct packed {
    logic              sop;
    logic              eop;
    logic [VID_DW-1:0] data;
  } vid_entry_t;

  function automatic int pix_cnt_w(input int w, input int h);
    return (w * h > 1) ? $clog2(w * h) : 1;
  endfunction

endpackage

// File: rtl/stream_fifo.sv
// Generic show-ahead synchronous FIFO with full/empty flags.
// Ports: clk_i, rst_ni (sync, active low), push_i/din_i, pop_i/dout_o, full_o, empty_o.
module stream_fifo #(
  parameter int W     = 26,
  parameter int DEPTH = 16
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0] mem_q [DEPTH];
  logic [AW:0]  wptr_q;
  logic [AW:0]  rptr_q;
  logic         wr;
  logic         rd;

  // Extra pointer bit tells full from empty when the indices meet.
  assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                   (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
  assign empty_o = (wptr_q == rptr_q);
  assign wr      = push_i & ~full_o;
  assign rd      = pop_i & ~empty_o;
  assign dout_o  = mem_q[rptr_q[AW-1:0]];

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      if (wr) wptr_q <= wptr_q + 1'b1;
      if (rd) rptr_q <= rptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (wr) mem_q[wptr_q[AW-1:0]] <= din_i;
  end

endmodule

// File: rtl/video_stream_source.sv
// Camera pixel stream to Avalon-ST video packets, one packet per frame.
// Ports: camera vsync/href/pix in, src_* Avalon-ST out, frame/drop counters, busy.
module video_stream_source
  import video_pkg::*;
#(
  parameter int WIDTH      = 320,
  parameter int HEIGHT     = 240,
  parameter int FIFO_DEPTH = 16,
  parameter int DATA_W     = VID_DW
) (
  input  logic              clk_clk,
  input  logic              reset_reset_n,
  input  logic              enable,
  input  logic              cam_vsync,
  input  logic              cam_href,
  input  logic              pix_valid,
  input  logic [DATA_W-1:0] pix_data,
  output logic [DATA_W-1:0] src_data,
  output logic              src_startofpacket,
  output logic              src_endofpacket,
  output logic              src_valid,
  input  logic              src_ready,
  output logic [15:0]       frame_count,
  output logic [15:0]       drop_count,
  output logic              busy
);

  localparam int CW = pix_cnt_w(WIDTH, HEIGHT);
  localparam logic [CW-1:0] LAST = CW'(WIDTH * HEIGHT - 1);

  logic              en_q, vs_q, vs_qq, hr_q, pv_q;
  logic [DATA_W-1:0] pd_q;
  vstate_t           state_q, state_d;
  vstate_t           next_q, next_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [15:0]       frame_q, frame_d;
  logic [15:0]       drop_q, drop_d;

  logic       rise, fall, accept;
  logic       push, full, empty;
  vid_entry_t wr, rd;

  assign rise   = vs_q & ~vs_qq;
  assign fall   = ~vs_q & vs_qq;
  assign accept = pv_q & hr_q;

  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      en_q    <= 1'b0;
      vs_q    <= 1'b0;
      vs_qq   <= 1'b0;
      hr_q    <= 1'b0;
      pv_q    <= 1'b0;
      pd_q    <= '0;
      state_q <= IDLE;
      next_q  <= IDLE;
      cnt_q   <= '0;
      frame_q <= '0;
      drop_q  <= '0;
    end else begin
      en_q    <= enable;
      vs_q    <= cam_vsync;
      vs_qq   <= vs_q;
      hr_q    <= cam_href;
      pv_q    <= pix_valid;
      pd_q    <= pix_data;
      state_q <= state_d;
      next_q  <= next_d;
      cnt_q   <= cnt_d;
      frame_q <= frame_d;
      drop_q  <= drop_d;
    end
  end

  always_comb begin
    state_d = state_q;
    next_d  = next_q;
    cnt_d   = cnt_q;
    frame_d = frame_q;
    drop_d  = drop_q;
    push    = 1'b0;
    wr      = '0;
    unique case (state_q)
      IDLE: begin
        if (en_q && rise) state_d = ARMED;
      end
      ARMED: begin
        if (fall) begin
          state_d = ACTIVE;
          cnt_d   = '0;
        end
      end
      ACTIVE: begin
        // A vsync rise wins over a same-cycle overflow: one filler only.
        if (rise) begin
          if (cnt_q == '0) begin
            state_d = ARMED;
          end else begin
            state_d = FLUSH;
            next_d  = en_q ? ARMED : IDLE;
          end
        end else if (accept) begin
          if (!full) begin
            push    = 1'b1;
            wr.sop  = (cnt_q == '0);
            wr.eop  = (cnt_q == LAST);
            wr.data = pd_q;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST) begin
              state_d = IDLE;
              frame_d = frame_q + 16'd1;
            end
          end else if (cnt_q == '0) begin
            drop_d  = drop_q + 16'd1;
            state_d = IDLE;
          end else begin
            state_d = FLUSH;
            next_d  = IDLE;
          end
        end
      end
      FLUSH: begin
        if (rise && en_q) next_d = ARMED;
        if (!full) begin
          push    = 1'b1;
          wr.eop  = 1'b1;
          drop_d  = drop_q + 16'd1;
          state_d = next_d;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  stream_fifo #(
    .W    ($bits(vid_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk_clk),
    .rst_ni (reset_reset_n),
    .push_i (push),
    .din_i  (wr),
    .pop_i  (src_ready),
    .dout_o (rd),
    .full_o (full),
    .empty_o(empty)
  );

  // Mask stale memory so the bus reads zero whenever nothing is offered.
  assign src_valid         = ~empty;
  assign src_data          = src_valid ? rd.data : '0;
  assign src_startofpacket = src_valid & rd.sop;
  assign src_endofpacket   = src_valid & rd.eop;
  assign frame_count       = frame_q;
  assign drop_count        = drop_q;
  assign busy              = (state_q != IDLE) | ~empty;

endmodule

// File: tb/tb_video_stream_source.sv
// Directed bench for video_stream_source: 4x2 frames on a depth-16 and a depth-4 instance.
// Words are captured at the falling edge and compared against hand-computed streams.
module tb_video_stream_source;

  logic        clk = 1'b0;
  logic        rst_n, enable, vs, hr, pv, ready;
  logic [23:0] pd;

  logic [23:0] d16, d4;
  logic        sop16, eop16, v16, busy16;
  logic        sop4, eop4, v4, busy4;
  logic [15:0] fc16, dc16, fc4, dc4;

  int passed = 0;
  int total  = 0;
  int cyc    = 0;
  int rmode  = 1;
  int pcyc   = 0;
  int first16 = -1;
  int stab16 = 0;
  int stab4  = 0;
  logic        st16 = 1'b0;
  logic        st4  = 1'b0;
  logic [25:0] pw16, pw4;
  logic [25:0] cap16[$];
  logic [25:0] cap4[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  video_stream_source #(
    .WIDTH(4), .HEIGHT(2), .FIFO_DEPTH(16), .DATA_W(24)
  ) u16 (
    .clk_clk(clk), .reset_reset_n(rst_n), .enable(enable),
    .cam_vsync(vs), .cam_href(hr), .pix_valid(pv), .pix_data(pd),
    .src_data(d16), .src_startofpacket(sop16), .src_endofpacket(eop16),
    .src_valid(v16), .src_ready(ready), .frame_count(fc16),
    .drop_count(dc16), .busy(busy16)
  );

  video_stream_source #(
    .WIDTH(4), .HEIGHT(2), .FIFO_DEPTH(4), .DATA_W(24)
  ) u4 (
    .clk_clk(clk), .reset_reset_n(rst_n), .enable(enable),
    .cam_vsync(vs), .cam_href(hr), .pix_valid(pv), .pix_data(pd),
    .src_data(d4), .src_startofpacket(sop4), .src_endofpacket(eop4),
    .src_valid(v4), .src_ready(ready), .frame_count(fc4),
    .drop_count(dc4), .busy(busy4)
  );

  always @(negedge clk) begin
    if (rst_n) begin
      if (v16 && ready) cap16.push_back({sop16, eop16, d16});
      if (v16 && first16 < 0) first16 = cyc;
      if (st16 && !(v16 && {sop16, eop16, d16} == pw16)) stab16++;
      st16 = v16 && !ready;
      pw16 = {sop16, eop16, d16};
      if (v4 && ready) cap4.push_back({sop4, eop4, d4});
      if (st4 && !(v4 && {sop4, eop4, d4} == pw4)) stab4++;
      st4 = v4 && !ready;
      pw4 = {sop4, eop4, d4};
    end else begin
      st16 = 1'b0;
      st4  = 1'b0;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  function automatic logic [25:0] getw(input bit w4, input int i);
    if (w4) return (i < cap4.size()) ? cap4[i] : '1;
    return (i < cap16.size()) ? cap16[i] : '1;
  endfunction

  task automatic chk_seq(input bit w4, input string tag, input int start,
                         input int n, input int base, input bit has_eop);
    logic [25:0] e;
    for (int i = 0; i < n; i++) begin
      e = {(i == 0), (has_eop && i == n - 1), 24'(base + i)};
      chk($sformatf("%s[%0d]", tag, i), 32'(getw(w4, start + i)), 32'(e));
    end
  endtask

  task automatic step(input bit v, input bit h, input bit p,
                      input logic [23:0] d);
    @(posedge clk);
    #1;
    vs = v; hr = h; pv = p; pd = d;
    case (rmode)
      0: ready = 1'b0;
      1: ready = 1'b1;
      default: ready = (cyc % 3 == 0);
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 24'h0);
  endtask

  task automatic vpulse();
    repeat (3) step(1'b1, 1'b0, 1'b0, 24'h0);
    idle(3);
  endtask

  task automatic pix(input int n, input int base);
    for (int i = 0; i < n; i++) begin
      step(1'b0, 1'b1, 1'b1, 24'(base + i));
      if (i == 0) pcyc = cyc;
    end
    idle(1);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
    cap16.delete();
    cap4.delete();
    first16 = -1;
  endtask

  initial begin
    rst_n = 1'b0; enable = 1'b0; vs = 1'b0; hr = 1'b0;
    pv = 1'b0; pd = '0; ready = 1'b1;

    // reset state and a full frame with ready held high
    do_reset();
    chk("rst_valid", 32'(v16), 32'd0);
    chk("rst_data", 32'(d16), 32'd0);
    chk("rst_frames", 32'(fc16), 32'd0);
    chk("rst_drops", 32'(dc16), 32'd0);
    chk("rst_busy", 32'(busy16), 32'd0);
    enable = 1'b1;
    vpulse();
    pix(8, 1);
    idle(10);
    chk("full_size", 32'(cap16.size()), 32'd8);
    chk_seq(1'b0, "full", 0, 8, 1, 1'b1);
    chk("full_frames", 32'(fc16), 32'd1);
    chk("full_drops", 32'(dc16), 32'd0);
    chk("full_latency", 32'(first16 - pcyc), 32'd2);
    chk("full_busy", 32'(busy16), 32'd0);

    // backpressure: ready one cycle in three
    do_reset();
    rmode = 2;
    vpulse();
    pix(8, 1);
    idle(30);
    rmode = 1;
    idle(1);
    chk("bp_size", 32'(cap16.size()), 32'd8);
    chk_seq(1'b0, "bp", 0, 8, 1, 1'b1);
    chk("bp_stable", 32'(stab16), 32'd0);
    chk("bp_frames", 32'(fc16), 32'd1);

    // overflow on the depth-4 instance
    do_reset();
    rmode = 0;
    vpulse();
    pix(8, 1);
    idle(4);
    chk("ovf_busy", 32'(busy4), 32'd1);
    chk("ovf_drops_wait", 32'(dc4), 32'd0);
    rmode = 1;
    idle(10);
    chk("ovf_size", 32'(cap4.size()), 32'd5);
    chk_seq(1'b1, "ovf", 0, 4, 1, 1'b0);
    chk("ovf_filler", 32'(getw(1'b1, 4)), 32'h0100_0000);
    chk("ovf_drops", 32'(dc4), 32'd1);
    chk("ovf_frames", 32'(fc4), 32'd0);
    vpulse();
    pix(8, 9);
    idle(10);
    chk("ovf2_size", 32'(cap4.size()), 32'd13);
    chk_seq(1'b1, "ovf2", 5, 8, 9, 1'b1);
    chk("ovf2_frames", 32'(fc4), 32'd1);
    chk("ovf2_drops", 32'(dc4), 32'd1);
    chk("ovf_stable", 32'(stab4), 32'd0);

    // short frame: vsync after 5 pixels
    do_reset();
    vpulse();
    pix(5, 1);
    vpulse();
    pix(8, 17);
    idle(10);
    chk("short_size", 32'(cap16.size()), 32'd14);
    chk_seq(1'b0, "short", 0, 5, 1, 1'b0);
    chk("short_filler", 32'(getw(1'b0, 5)), 32'h0100_0000);
    chk_seq(1'b0, "short2", 6, 8, 17, 1'b1);
    chk("short_drops", 32'(dc16), 32'd1);
    chk("short_frames", 32'(fc16), 32'd1);

    // enable gating
    do_reset();
    enable = 1'b0;
    vpulse();
    pix(8, 1);
    idle(5);
    chk("en0_size", 32'(cap16.size()), 32'd0);
    chk("en0_busy", 32'(busy16), 32'd0);
    enable = 1'b1;
    vpulse();
    pix(3, 1);
    enable = 1'b0;
    pix(5, 4);
    idle(5);
    vpulse();
    pix(8, 33);
    idle(10);
    chk("endrop_size", 32'(cap16.size()), 32'd8);
    chk_seq(1'b0, "endrop", 0, 8, 1, 1'b1);
    chk("endrop_frames", 32'(fc16), 32'd1);
    chk("endrop_drops", 32'(dc16), 32'd0);
    chk("endrop_busy", 32'(busy16), 32'd0);

    // reset in the middle of a frame
    do_reset();
    enable = 1'b1;
    vpulse();
    pix(8, 1);
    idle(5);
    chk("mid_pre_frames", 32'(fc16), 32'd1);
    vpulse();
    pix(3, 1);
    chk("mid_pre_busy", 32'(busy16), 32'd1);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    chk("mid_valid", 32'(v16), 32'd0);
    chk("mid_frames", 32'(fc16), 32'd0);
    chk("mid_busy", 32'(busy16), 32'd0);
    rst_n = 1'b1;
    cap16.delete();
    cap4.delete();
    idle(1);
    vpulse();
    pix(8, 65);
    idle(10);
    chk("mid_size", 32'(cap16.size()), 32'd8);
    chk_seq(1'b0, "mid", 0, 8, 65, 1'b1);
    chk("mid_frames2", 32'(fc16), 32'd1);
    chk("all_stable", 32'(stab16), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/video_stream_source.md
Name: video_stream_source

Overview:
- Converts a camera-side pixel stream (vsync/href/pixel strobe, already in the system clock domain and converted to RGB888) into Avalon-ST video packets.
- Feeds the 24-bit video DMA sink of the EDL_Final system: one packet per frame, SOP on the first pixel, EOP on the last.
- Buffers pixels in a small FIFO to absorb sink backpressure.
- Guarantees well-formed packets under overflow and short frames by terminating with a filler EOP word.

Parameters:
- WIDTH, 320, active pixels per line
- HEIGHT, 240, active lines per frame
- FIFO_DEPTH, 16, output FIFO entries (power of 2, >=4)
- DATA_W, 24, pixel width (RGB888)

Ports:
- clk_clk  in  1  system clock
- reset_reset_n  in  1  synchronous active-low reset
- enable  in  1  capture enable
- cam_vsync  in  1  high during vertical blanking
- cam_href  in  1  high during active line
- pix_valid  in  1  one-cycle strobe, pixel present
- pix_data  in  DATA_W  pixel
- src_data  out  DATA_W  Avalon-ST data
- src_startofpacket  out  1  first pixel of frame
- src_endofpacket  out  1  last word of frame
- src_valid  out  1  word valid
- src_ready  in  1  sink ready, readyLatency 0
- frame_count  out  16  completed full frames, wraps
- drop_count  out  16  frames truncated or dropped, wraps
- busy  out  1  state != IDLE or FIFO non-empty

Behaviour:
- Reset: synchronous on the clk_clk edge while reset_reset_n=0.
  - All outputs 0, FIFO emptied, counters 0, state IDLE.
  - Reset mid-packet leaves the packet unterminated; the downstream side is reset by the same reset.
- Input sampling:
  - Inputs are registered once.
  - vsync rise and fall are detected on the registered copy.
  - A pixel is accepted when pix_valid & cam_href are both high in ACTIVE.
- FIFO:
  - Show-ahead FIFO, entry = {sop, eop, data}.
  - Output pops on src_valid & src_ready.
  - src_data/sop/eop stay stable while src_valid & !src_ready.
  - src_valid = FIFO non-empty.
- Latency: an accepted pixel with the FIFO empty appears on src_valid exactly 2 cycles after its pix_valid cycle.
- Pixel counter: 0..WIDTH*HEIGHT-1, width $clog2(WIDTH*HEIGHT).
  - sop = (cnt==0).
  - eop = (cnt==WIDTH*HEIGHT-1).
- States:
  - IDLE: pixels ignored. enable & vsync rise -> ARMED.
  - ARMED: pixels ignored. vsync fall -> ACTIVE, cnt=0.
  - ACTIVE, accepted pixel with FIFO not full: push the pixel and increment cnt.
    - If that push is the eop word -> IDLE, frame_count+1.
  - ACTIVE, accepted pixel with FIFO full (overflow): pixel discarded.
    - cnt==0 (nothing of this frame written): drop silently, drop_count+1 -> IDLE.
    - Otherwise -> FLUSH, with next=IDLE.
  - ACTIVE, vsync rise with cnt incomplete (short frame):
    - cnt==0: -> ARMED, no count change.
    - Otherwise -> FLUSH, with next=ARMED if enable, else IDLE.
  - FLUSH: all pixels discarded. When the FIFO is not full, push filler {sop=0, eop=1, data=0}, drop_count+1, go to next.
    - A vsync rise while in FLUSH sets next=ARMED if enable.
- Simultaneous overflow and vsync rise in the same cycle: treated as a short frame. One filler, one drop_count increment.
- Deasserting enable mid-frame: the current frame completes normally, then IDLE. enable is only checked at vsync rise.
- Extra pixels after EOP or outside href: ignored.
- Packet invariant: every emitted SOP is followed by exactly one EOP before the next SOP.

Decomposition:
- Shared package video_pkg holds:
  - state enum (IDLE, ARMED, ACTIVE, FLUSH)
  - FIFO entry struct {sop, eop, data}
  - PIX_CNT_W function
- Sub-module: stream_fifo, a generic show-ahead synchronous FIFO with full/empty flags, parameterized width/depth. It is reusable by other Avalon-ST blocks.

Test Plan:
- Full frame, WIDTH=4, HEIGHT=2, src_ready=1, continuous pixels 0x000001..0x000008 -> 8 words; SOP only on 0x000001, EOP only on 0x000008; frame_count=1; first src_valid 2 cycles after first pix_valid.
- Backpressure: same frame, src_ready toggled 1-of-3 cycles -> identical 8-word sequence; data/sop/eop held stable while not ready; no loss with FIFO_DEPTH=16.
- Overflow: FIFO_DEPTH=4, src_ready=0 throughout 8 pixels, then ready=1 -> 4 pixel words, then filler {eop=1, data=0}; drop_count=1; frame_count=0; next frame captured normally.
- Short frame: vsync rises after 5 of 8 pixels -> 5 words plus filler EOP; drop_count=1; the following frame starts with SOP and completes with frame_count=1.
- Enable gating: enable=0 at vsync rise -> no output for that frame; enable dropped mid-frame -> that frame completes with EOP, the next frame is ignored.
- Reset mid-frame after 3 pixels -> outputs and counters 0 next cycle; the next enabled frame starts cleanly with SOP.
